mult_div_seq: RTL
=================

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request pulse from the main control FSM; sampled only in IDLE.
REQ-004 SHALL have port: op  input  1  0 = MULT (signed), 1 = DIV (signed).
REQ-005 SHALL have port: a  input  32  rs operand (multiplicand or dividend).
REQ-006 SHALL have port: b  input  32  rt operand (multiplier or divisor).
REQ-007 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: HILOWrite  output  1  one-cycle pulse, high with done when hi/lo were updated.
REQ-010 SHALL have port: Div0  output  1  one-cycle pulse, high with done on DIV with b == 0.
REQ-011 SHALL have port: hi  output  32  HI register (product[63:32] or remainder).
REQ-012 SHALL have port: lo  output  32  LO register (product[31:0] or quotient).

Function
REQ-013 SHALL implement states IDLE, MRUN, DRUN, FIX and DONE with a 5-bit iteration counter.
REQ-014 SHALL transition IDLE->MRUN (op=0) or IDLE->DRUN (op=1, b!=0) on start=1, latching a, b, op, operand signs and magnitudes, and clearing the counter.
REQ-015 SHALL transition IDLE->DONE on start=1 with op=1 and b==0, setting Div0=1 and HILOWrite=0 in DONE and leaving hi/lo unchanged.
REQ-016 SHALL perform one unsigned shift-add iteration on the magnitudes per MRUN cycle and move to FIX after 32 iterations (counter==31).
REQ-017 SHALL perform one restoring shift-subtract iteration on the magnitudes per DRUN cycle and move to FIX after 32 iterations.
REQ-018 SHALL, in FIX, apply the sign correction and load hi/lo: MULT {hi,lo} = 64-bit two's-complement product; DIV lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
REQ-019 SHALL go FIX->DONE; DONE asserts done=1 (plus HILOWrite=1 unless Div0) for exactly one cycle, then returns to IDLE.
REQ-020 SHALL give fixed latency: start cycle = 0, MRUN/DRUN cycles 1-32, FIX cycle 33, done high in cycle 34; divide-by-zero gives done in cycle 1.
REQ-021 SHALL ignore start in every state other than IDLE, including DONE.
REQ-022 SHALL ignore changes on a, b and op after acceptance.
REQ-023 SHALL hold hi/lo stable between updates; they are valid whenever busy=0.
REQ-024 SHALL wrap DIV 0x80000000 / 0xFFFFFFFF to lo=0x80000000, hi=0 without raising any flag.
REQ-025 SHALL produce no overflow indication for MULT, since the full 64-bit result is always representable.

Reset
REQ-026 SHALL, on reset=1 at any clock edge (including mid-operation), enter IDLE and clear hi, lo, counter, busy, done, HILOWrite and Div0 to 0.
REQ-027 SHALL give reset priority over start in the same cycle.

Verification
REQ-028 SHALL cover: MULT a=7, b=0xFFFFFFFD -> cycle 34 done=1, HILOWrite=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-029 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> cycle 34 lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-030 SHALL cover: DIV a=5, b=0 with hi/lo preloaded -> cycle 1 done=1, Div0=1, HILOWrite=0, hi/lo unchanged.
REQ-031 SHALL cover: MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-032 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL cover: MULT started, start re-pulsed at cycle 5 (ignored), reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/mult_div_seq.sv
// Sequential signed 32x32 multiply / 32/32 divide unit driving the HI/LO register pair.
// Works on operand magnitudes for 32 iterations, then applies sign correction in a fix-up cycle.
module mult_div_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        HILOWrite,
  output logic        Div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {StIdle, StMrun, StDrun, StFix, StDone} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        op_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic [31:0] mag_b_q;
  // MULT: {partial high, multiplier/low product}; DIV: {remainder, dividend/quotient}
  logic [63:0] acc_q;
  logic        busy_q;
  logic        done_q;
  logic        hilo_we_q;
  logic        div0_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    mag_a     = a[31] ? (32'd0 - a) : a;
    mag_b     = b[31] ? (32'd0 - b) : b;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
    div_shift = acc_q[63:31];
    div_diff  = div_shift - {1'b0, mag_b_q};
    prod_fix  = (sign_a_q ^ sign_b_q) ? (64'd0 - acc_q) : acc_q;
    quo_fix   = (sign_a_q ^ sign_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    // Remainder takes the sign of the dividend
    rem_fix   = sign_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      op_q      <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      mag_b_q   <= 32'd0;
      acc_q     <= 64'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hilo_we_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      done_q    <= 1'b0;
      hilo_we_q <= 1'b0;
      div0_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= op;
            sign_a_q <= a[31];
            sign_b_q <= b[31];
            mag_b_q  <= mag_b;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b1;
            if (op && (b == 32'd0)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              div0_q  <= 1'b1;
            end else begin
              acc_q   <= {32'd0, mag_a};
              state_q <= op ? StDrun : StMrun;
            end
          end
        end
        StMrun: begin
          acc_q <= {mul_sum, acc_q[31:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StFix;
        end
        StDrun: begin
          if (!div_diff[32]) acc_q <= {div_diff[31:0], acc_q[30:0], 1'b1};
          else               acc_q <= {div_shift[31:0], acc_q[30:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StFix;
        end
        StFix: begin
          if (op_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          state_q   <= StDone;
          done_q    <= 1'b1;
          hilo_we_q <= 1'b1;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign HILOWrite = hilo_we_q;
  assign Div0      = div0_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
